// File: rtl/interpolation_unit_ctrl.sv
// Sequencing control for the interpolation datapath: window fill/stream/drain,
// tracking of results in the 2-cycle datapath pipe, and a 2-deep result FIFO.
module interpolation_unit_ctrl #(
    parameter int pix_width = 9,
    parameter int dec_width = 15,
    localparam int IW = pix_width + dec_width + 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [4:0]    win_dim_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          in_val,
    output logic          in_rdy,
    output logic          pix_val,
    output logic          enq_val,
    output logic          deq_rdy,
    output logic          row_counter_en,
    output logic [4:0]    win_dim,
    input  logic [IW-1:0] pix_interp,
    output logic          out_val,
    input  logic          out_rdy,
    output logic [IW-1:0] out_msg
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [4:0]    wd_q, wd_d;
    logic [4:0]    col_q, col_d;
    logic [4:0]    row_q, row_d;
    logic [1:0]    infl_q, infl_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [IW-1:0] fifo_q [2];

    logic          start_ok, active, last_col, produce_next;
    logic          in_rdy_c, xfer, push, pop, err_c, done_c;
    logic [2:0]    outstanding;

    assign start_ok     = start && (win_dim_in != 5'd0) && (win_dim_in <= 5'd16);
    assign active       = (state_q == FILL) || (state_q == STREAM);
    assign last_col     = (col_q == wd_q);
    assign produce_next = (row_q != 5'd0) && (col_q != 5'd0);
    // Results still owed: parked in the FIFO plus those travelling the datapath pipe.
    assign outstanding  = {1'b0, cnt_q} + {2'b0, infl_q[0]} + {2'b0, infl_q[1]};
    assign in_rdy_c     = active && (!produce_next || (outstanding < 3'd2));
    assign xfer         = in_val && in_rdy_c;
    assign push         = infl_q[1];
    assign pop          = (cnt_q != 2'd0) && out_rdy;

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        col_d    = col_q;
        row_d    = row_q;
        err_c    = 1'b0;
        done_c   = 1'b0;
        infl_d   = {infl_q[0], xfer && produce_next};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    wd_d    = win_dim_in;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = FILL;
                end else begin
                    err_c = start;
                end
            end
            FILL, STREAM: begin
                if (xfer) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 5'd1;
                        if (state_q == FILL) begin
                            state_d = STREAM;
                        end else if (row_q == wd_q) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                if ((infl_q == 2'b00) && (cnt_q == 2'd0)) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wd_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            infl_q    <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            col_q    <= col_d;
            row_q    <= row_d;
            infl_q   <= infl_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= pix_interp;
            end
        end
    end

    // err is driven straight from the start input, so it is masked while reset is held.
    assign err            = err_c && reset;
    assign done           = done_c;
    assign busy           = (state_q != IDLE);
    assign in_rdy         = in_rdy_c;
    assign pix_val        = xfer;
    assign enq_val        = xfer && (row_q != wd_q);
    assign deq_rdy        = xfer && (state_q == STREAM);
    assign row_counter_en = xfer && last_col;
    assign win_dim        = wd_q;
    assign out_val        = (cnt_q != 2'd0);
    assign out_msg        = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_interpolation_unit_ctrl.sv
// Directed and randomised bench for interpolation_unit_ctrl against a job-level reference model.
module tb_interpolation_unit_ctrl;

    localparam int IW = 26;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    win_dim_in = '0;
    logic          in_val = 1'b0;
    logic          out_rdy = 1'b0;
    logic [IW-1:0] pix_interp = '0;
    logic          busy, done, err, in_rdy, pix_val, enq_val, deq_rdy, row_counter_en, out_val;
    logic [4:0]    win_dim;
    logic [IW-1:0] out_msg;

    interpolation_unit_ctrl #(.pix_width(9), .dec_width(15)) dut (
        .clk(clk), .reset(reset), .start(start), .win_dim_in(win_dim_in),
        .busy(busy), .done(done), .err(err), .in_val(in_val), .in_rdy(in_rdy),
        .pix_val(pix_val), .enq_val(enq_val), .deq_rdy(deq_rdy),
        .row_counter_en(row_counter_en), .win_dim(win_dim), .pix_interp(pix_interp),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit rand_mode = 1'b0;
    logic in_val_lvl = 1'b0;
    logic out_rdy_lvl = 1'b1;

    // Reference model: a job is a count of accepted pixels; results owed are a queue.
    typedef struct {int smp; int rdy; logic [IW-1:0] val;} ent_t;
    typedef enum {M_IDLE, M_ACT, M_DRAIN} mst_e;
    ent_t q[$];
    mst_e ms = M_IDLE;
    int   mw = 0;
    int   k = 0;

    int job_x = 0, job_o = 0, job_r = 0, job_d0 = 0;
    int last_x = 0, last_o = 0, last_r = 0;
    int done_cnt = 0, err_cnt = 0;
    int start_cyc = 0, first_out_cyc = 0, done_cyc = 0;
    logic [IW-1:0] first_out_val = '0;
    logic [31:0]   job_enq = '0, job_deq = '0;

    int r, col;
    bit prod, e_rdy, e_x, e_enq, e_deq, e_rce, e_err, e_oval, e_done, accept;

    function automatic logic [IW-1:0] hashv(input int c);
        logic [31:0] x;
        x = 32'(c) * 32'h9E3779B1;
        x = x ^ (x >> 13);
        return x[IW-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        start = 1'b0;
        pix_interp = hashv(cyc);
        if (rand_mode) begin
            in_val  = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
        end else begin
            in_val  = in_val_lvl;
            out_rdy = out_rdy_lvl;
        end
    endtask

    task automatic begin_job(input int w);
        job_d0     = done_cnt;
        start      = 1'b1;
        win_dim_in = 5'(w);
    endtask

    task automatic finish_job(input int w, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != job_d0) break;
            step();
        end
        check("job_done_once", done_cnt - job_d0, 1);
        check("job_xfers", last_x, (w + 1) * (w + 1));
        check("job_outputs", last_o, w * w);
        check("job_row_en", last_r, w + 1);
    endtask

    task automatic wait_row(input int rows);
        for (int i = 0; i < 400; i++) begin
            if (job_r >= rows) break;
            step();
        end
        check("wait_row", 32'(job_r >= rows), 1);
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            ms = M_IDLE;
            mw = 0;
            k  = 0;
            check("rst_ctl", 32'({busy, done, err, in_rdy, out_val, pix_val, enq_val, deq_rdy, row_counter_en}), 0);
            check("rst_win_dim", 32'(win_dim), 0);
            check("rst_out_msg", 32'(out_msg), 0);
        end else begin
            r = 0; col = 0; prod = 1'b0; e_rdy = 1'b0;
            if (ms == M_ACT) begin
                r     = k / (mw + 1);
                col   = k % (mw + 1);
                prod  = (r >= 1) && (col >= 1);
                e_rdy = !prod || (q.size() < 2);
            end
            e_x    = in_val && e_rdy;
            e_enq  = e_x && (r != mw);
            e_deq  = e_x && (r >= 1);
            e_rce  = e_x && (col == mw);
            e_err  = (ms == M_IDLE) && start && ((win_dim_in == 5'd0) || (win_dim_in > 5'd16));
            accept = (ms == M_IDLE) && start && (win_dim_in >= 5'd1) && (win_dim_in <= 5'd16);
            e_oval = 1'b0;
            if (q.size() > 0) e_oval = (q[0].rdy <= cyc);
            e_done = (ms == M_DRAIN) && (q.size() == 0);

            check("busy", 32'(busy), 32'(ms != M_IDLE));
            check("in_rdy", 32'(in_rdy), 32'(e_rdy));
            check("pix_val", 32'(pix_val), 32'(e_x));
            check("enq_val", 32'(enq_val), 32'(e_enq));
            check("deq_rdy", 32'(deq_rdy), 32'(e_deq));
            check("row_counter_en", 32'(row_counter_en), 32'(e_rce));
            check("err", 32'(err), 32'(e_err));
            check("done", 32'(done), 32'(e_done));
            check("win_dim", 32'(win_dim), 32'(mw));
            check("out_val", 32'(out_val), 32'(e_oval));
            if (e_oval) check("out_msg", 32'(out_msg), 32'(q[0].val));

            if (pix_val) begin
                if (job_x < 32) begin
                    job_enq[job_x] = enq_val;
                    job_deq[job_x] = deq_rdy;
                end
                job_x++;
            end
            if (out_val && out_rdy) begin
                if (job_o == 0) begin
                    first_out_cyc = cyc;
                    first_out_val = out_msg;
                end
                job_o++;
            end
            if (row_counter_en) job_r++;
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                last_x = job_x;
                last_o = job_o;
                last_r = job_r;
            end

            foreach (q[i]) if (q[i].smp == cyc) q[i].val = pix_interp;
            if (e_oval && out_rdy) void'(q.pop_front());
            if (e_x) begin
                if (prod) q.push_back('{cyc + 2, cyc + 3, '0});
                k++;
                if (k == (mw + 1) * (mw + 1)) ms = M_DRAIN;
            end
            if (e_done) ms = M_IDLE;
            if (accept) begin
                ms = M_ACT;
                mw = int'(win_dim_in);
                k  = 0;
                job_x = 0; job_o = 0; job_r = 0;
                job_enq = '0; job_deq = '0;
                start_cyc = cyc;
            end
        end
    end

    initial begin
        #990000;
        n_err++;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, d0;
        pix_interp = hashv(0);
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();

        // Smallest window, full throughput: timing pinned by hand.
        in_val_lvl = 1'b1; out_rdy_lvl = 1'b1;
        begin_job(1);
        finish_job(1, 50);
        check("w1_first_out_lat", first_out_cyc - start_cyc, 7);
        check("w1_done_lat", done_cyc - start_cyc, 8);
        check("w1_out_value", 32'(first_out_val), 32'(hashv(start_cyc + 6)));
        check("w1_enq_pattern", job_enq, 32'h3);
        check("w1_deq_pattern", job_deq, 32'hC);

        // Bad configurations.
        e0 = err_cnt;
        start = 1'b1; win_dim_in = 5'd0;
        step();
        start = 1'b1; win_dim_in = 5'd17;
        step();
        step();
        check("err_pulses", err_cnt - e0, 2);
        check("err_busy", 32'(busy), 0);

        // Start while busy is ignored.
        begin_job(3);
        repeat (5) step();
        start = 1'b1; win_dim_in = 5'd5;
        step();
        #2;
        check("busy_start_wd", 32'(win_dim), 3);
        finish_job(3, 300);

        // Largest window.
        begin_job(16);
        finish_job(16, 2000);

        // Output back-pressure mid-stream.
        begin_job(4);
        wait_row(2);
        out_rdy_lvl = 1'b0;
        repeat (21) step();
        #2;
        check("stall_in_rdy", 32'(in_rdy), 0);
        check("stall_out_val", 32'(out_val), 1);
        out_rdy_lvl = 1'b1;
        finish_job(4, 500);

        // Asynchronous reset mid-job, then a fresh job.
        begin_job(3);
        wait_row(2);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_ctl", 32'({busy, done, err, in_rdy, out_val, pix_val, enq_val, deq_rdy, row_counter_en}), 0);
        check("async_rst_msg", 32'(out_msg), 0);
        d0 = done_cnt;
        step();
        step();
        reset = 1'b1;
        step();
        check("abort_no_done", done_cnt - d0, 0);
        begin_job(2);
        finish_job(2, 200);

        // Random handshakes over many jobs.
        rand_mode = 1'b1;
        for (int j = 0; j < 200; j++) begin
            begin_job(7);
            finish_job(7, 3000);
        end
        rand_mode = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/interpolation_unit_ctrl.md
INTERPOLATION_UNIT_CTRL -- requirements
Module: interpolation_unit_ctrl

Interface
REQ-001 SHALL have parameter pix_width, 9, pixel width (matches datapath).
REQ-002 SHALL have parameter dec_width, 15, weight fraction width; interp width = pix_width+dec_width+2 (26).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have ports start in 1, win_dim_in in 5: start pulse; window last index (window is (win_dim+1)^2 pixels).
REQ-006 SHALL have ports busy out 1, done out 1, err out 1: job active; 1-cycle job-complete pulse; 1-cycle bad-config pulse.
REQ-007 SHALL have ports in_val in 1, in_rdy out 1: pixel stream handshake (pixel data is wired to datapath pix directly).
REQ-008 SHALL have ports pix_val out 1, enq_val out 1, deq_rdy out 1, row_counter_en out 1, win_dim out 5: datapath controls.
REQ-009 SHALL have port pix_interp in 26: datapath result register output.
REQ-010 SHALL have ports out_val out 1, out_rdy in 1, out_msg out 26: interpolated result stream.

Function
REQ-011 SHALL implement FSM IDLE, FILL, STREAM, DRAIN; busy=1 in every state except IDLE.
REQ-012 IDLE: start=1 with 1<=win_dim_in<=16 SHALL latch win_dim, clear counters, go FILL; start with win_dim_in 0 or >16 SHALL pulse err, stay IDLE.
REQ-013 start while busy SHALL be ignored (no err, no relatch).
REQ-014 Transfer SHALL occur when in_val && in_rdy; pix_val = transfer, combinationally.
REQ-015 Internal col (0..win_dim) SHALL increment per transfer, wrap to 0 after win_dim; row SHALL increment when col wraps; row_counter_en = transfer && col==win_dim.
REQ-016 FILL (row 0): enq_val=transfer, deq_rdy=0; transfer at col==win_dim SHALL go STREAM.
REQ-017 STREAM (rows 1..win_dim): deq_rdy=transfer; enq_val=transfer except on row==win_dim (enq_val=0).
REQ-018 Transfer at row==win_dim, col==win_dim SHALL go DRAIN; in_rdy=0 in DRAIN and IDLE.
REQ-019 A transfer at row>=1 && col>=1 is output-producing; exactly win_dim^2 per job.
REQ-020 Output-producing transfer in cycle t SHALL cause pix_interp sampled at end of cycle t+2 to be written into a 2-entry output FIFO; 2-bit in-flight shift-valid tracks t+1, t+2.
REQ-021 out_val = FIFO non-empty; out_msg = FIFO head; pop on out_val && out_rdy; earliest out_val is cycle t+3; simultaneous push and pop allowed when full.
REQ-022 in_rdy in FILL/STREAM SHALL be 1 iff (FIFO occupancy + in-flight count) < 2, or next transfer is not output-producing (row 0 or col 0).
REQ-023 Results SHALL be delivered in transfer order, never dropped or duplicated, for any out_rdy pattern.
REQ-024 DRAIN SHALL exit to IDLE when in-flight=0 and FIFO empty; done=1 on that transition cycle only.
REQ-025 win_dim output SHALL hold latched value from start until next accepted start.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, counters 0, FIFO and in-flight empty, win_dim=0, and all outputs 0 (busy, done, err, in_rdy, out_val, pix_val, enq_val, deq_rdy, row_counter_en, out_msg).
REQ-027 reset mid-job SHALL abandon the job with no done pulse; first start after deassertion SHALL behave as from power-up.

Verification
REQ-028 win_dim=1, in_val always 1, out_rdy always 1 -> 4 transfers, enq_val on transfers 0-1, deq_rdy on 2-3, enq_val=0 on 2-3, one out_val 3 cycles after transfer 3 carrying pix_interp from 2 cycles after it, done pulse next.
REQ-029 win_dim=16, full throughput -> 289 transfers, 256 outputs in order, row_counter_en pulses 17 times, done exactly once.
REQ-030 win_dim=4, out_rdy=0 for 20 cycles mid-STREAM -> in_rdy drops after 2 outstanding results, FIFO holds 2, no loss; resume yields 16 results total.
REQ-031 start with win_dim_in=0, then 17 -> err pulse each, busy stays 0; start during busy job -> ignored, win_dim unchanged.
REQ-032 reset=0 asynchronously at row 2 of win_dim=3 job -> all outputs 0 same cycle, no done; new job win_dim=2 afterwards completes with 4 outputs.
REQ-033 Random in_val/out_rdy (50%), win_dim=7, 200 jobs -> 49 outputs per job matching scoreboard of pix_interp at transfer+2.
